// File: rtl/disp_axi_pkg.sv
// disp_axi_pkg: shared state encodings, burst constants and log2 helper for the display VRAM slave
package disp_axi_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_BURST = 2'b10
  } state_t;
  localparam int BURST_BYTES = 256;
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/disp_skidbuf.sv
// disp_skidbuf: 2-entry registered output stage (output register plus skid) with occupancy report
module disp_skidbuf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);
  logic         sv;
  logic [W-1:0] sd;
  logic         free;
  assign free = !out_valid | out_ready;
  // entries still held after this edge, so a draining output register does not block issue
  assign occ = 2'(sv) + 2'(out_valid & !out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sv        <= 1'b0;
      sd        <= '0;
    end else if (free) begin
      out_valid <= sv | in_valid;
      if (sv) out_data <= sd;
      else if (in_valid) out_data <= in_data;
      sv <= sv & in_valid;
      if (in_valid) sd <= in_data;
    end else if (in_valid) begin
      sv <= 1'b1;
      sd <= in_data;
    end
  end
endmodule

// File: rtl/disp_vram_rdslave.sv
// disp_vram_rdslave: fixed-length AXI4-style read burst responder fronting a synchronous-read SRAM
module disp_vram_rdslave
  import disp_axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 64,
  parameter int MEM_AW    = 16
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              RLAST,
  output logic              MEM_RDEN,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  localparam int OFS = log2(DATA_W / 8);
  localparam int CW  = log2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  state_t            state;
  logic              pend_valid, inflight;
  logic [MEM_AW-1:0] pend_addr, addr;
  logic [CW-1:0]     issued, returned;
  logic [1:0]        occ;
  logic [DATA_W:0]   rout;
  logic              hs, start, reload, ret_last, addr_unused;
  assign hs          = ARVALID & ARREADY;
  assign start       = pend_valid & (state == S_IDLE);
  assign reload      = (state == S_BURST) & MEM_RDEN & (issued == LAST) & pend_valid;
  assign ret_last    = returned == LAST;
  assign addr_unused = ^{ARADDR[31:MEM_AW+OFS], ARADDR[OFS-1:0]};
  // an idle slave issues straight from the pending entry so the first read leaves the cycle after AR
  assign MEM_RDEN    = ((state == S_BURST) | pend_valid) & ((occ + 2'(inflight)) < 2'd2);
  assign MEM_ADDR    = (state == S_BURST) ? addr : pend_addr;
  assign {RLAST, RDATA} = rout;
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state      <= S_IDLE;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      addr       <= '0;
      issued     <= '0;
      returned   <= '0;
      inflight   <= 1'b0;
      ARREADY    <= 1'b0;
    end else begin
      inflight <= MEM_RDEN;
      if (inflight) returned <= ret_last ? '0 : returned + 1'b1;
      if (start) begin
        state  <= S_BURST;
        addr   <= pend_addr + MEM_AW'(MEM_RDEN);
        issued <= CW'(MEM_RDEN);
      end else if (MEM_RDEN) begin
        if (issued != LAST) begin
          addr   <= addr + 1'b1;
          issued <= issued + 1'b1;
        end else if (pend_valid) begin
          addr   <= pend_addr;
          issued <= '0;
        end else state <= S_IDLE;
      end
      if (hs) begin
        pend_valid <= 1'b1;
        pend_addr  <= ARADDR[MEM_AW+OFS-1:OFS];
        ARREADY    <= 1'b0;
      end else if (start | reload) begin
        pend_valid <= 1'b0;
        ARREADY    <= 1'b1;
      end else ARREADY <= !pend_valid;
    end
  end
  disp_skidbuf #(.W(DATA_W + 1)) u_skid (
    .clk      (ACLK),
    .rst      (ARST),
    .in_valid (inflight),
    .in_data  ({ret_last, MEM_RDATA}),
    .out_valid(RVALID),
    .out_data (rout),
    .out_ready(RREADY),
    .occ      (occ)
  );
endmodule

// File: tb/tb_disp_vram_rdslave.sv
// tb_disp_vram_rdslave: scoreboard bench; SRAM word n holds n, expected beats queued at AR issue
module tb_disp_vram_rdslave;
  logic        ACLK = 0;
  logic        ARST, ARVALID, ARREADY, RVALID, RREADY, RLAST, MEM_RDEN;
  logic [31:0] ARADDR, RDATA, MEM_RDATA;
  logic [15:0] MEM_ADDR;
  int          tests = 0, fails = 0, beats = 0, outstanding = 0, run = 0, max_run = 0, k = 0;
  logic        bp = 0, stall = 0, hold_l;
  logic [31:0] hold_d;
  logic [3:0]  pat = 4'b1001;
  logic [32:0] exp_q[$];
  logic [15:0] addr_q[$];
  logic [32:0] e_beat;
  logic [15:0] e_addr;
  disp_vram_rdslave dut (
    .ACLK(ACLK), .ARST(ARST), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .MEM_RDEN(MEM_RDEN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA)
  );
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) MEM_RDATA <= 32'(MEM_ADDR);
  initial begin
    RREADY = 1;
    forever begin
      @(posedge ACLK); #1;
      RREADY = bp ? pat[k%4] : 1'b1;
      k++;
    end
  end
  always @(negedge ACLK) begin
    if (ARST) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      run = 0;
      stall = 0;
    end else begin
      if (MEM_RDEN) begin
        tests++;
        if (addr_q.size() == 0) begin
          fails++;
          $display("FAIL mem_addr unexpected read at %h, required no read", MEM_ADDR);
        end else begin
          e_addr = addr_q.pop_front();
          if (MEM_ADDR !== e_addr) begin
            fails++;
            $display("FAIL mem_addr got %h required %h", MEM_ADDR, e_addr);
          end
        end
      end
      if (stall) begin
        tests++;
        if (RVALID !== 1'b1 || RDATA !== hold_d || RLAST !== hold_l) begin
          fails++;
          $display("FAIL stall_stable got v=%b d=%h l=%b required v=1 d=%h l=%b", RVALID, RDATA, RLAST, hold_d, hold_l);
        end
      end
      if (RVALID && RREADY) begin
        tests++;
        beats++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat unexpected d=%h l=%b", RDATA, RLAST);
        end else begin
          e_beat = exp_q.pop_front();
          if ({RLAST, RDATA} !== e_beat) begin
            fails++;
            $display("FAIL beat got l=%b d=%h required l=%b d=%h", RLAST, RDATA, e_beat[32], e_beat[31:0]);
          end
        end
      end
      stall  = RVALID & !RREADY;
      hold_d = RDATA;
      hold_l = RLAST;
      outstanding = outstanding + int'(MEM_RDEN) - int'(RVALID & RREADY);
      tests++;
      if (outstanding > 3) begin
        fails++;
        $display("FAIL outstanding got %0d required <= 3", outstanding);
      end
      run = (RVALID && RREADY) ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask
  task automatic send_ar(input logic [31:0] a);
    int t;
    logic [15:0] w;
    w = a[17:2];
    ARADDR = a;
    ARVALID = 1;
    t = 0;
    while (!ARREADY && t < 500) begin
      @(posedge ACLK); #1;
      t++;
    end
    tests++;
    if (!ARREADY) begin
      fails++;
      $display("FAIL ar_handshake timeout arready=%b required 1", ARREADY);
      ARVALID = 0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        exp_q.push_back({i == 63, 32'(16'(w + 16'(i)))});
        addr_q.push_back(16'(w + 16'(i)));
      end
      @(posedge ACLK); #1;
      ARVALID = 0;
    end
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge ACLK); #1;
      t++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain remaining=%0d required 0", exp_q.size());
      exp_q.delete();
      addr_q.delete();
    end
    repeat (3) @(posedge ACLK);
    #1;
  endtask
  initial begin
    int t, base;
    ARST = 1; ARVALID = 0; ARADDR = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_outputs", {RDATA, 12'h0, MEM_ADDR, ARREADY, RVALID, RLAST, MEM_RDEN}, 64'h0);
    ARST = 0;
    @(posedge ACLK); #1;
    check("arready_after_reset", 64'(ARREADY), 64'h1);
    send_ar(32'h0000_0100);
    check("rden_after_ar", {MEM_RDEN, MEM_ADDR}, {1'b1, 16'h0040});
    @(posedge ACLK); #1;
    check("rvalid_t1", 64'(RVALID), 64'h0);
    @(posedge ACLK); #1;
    check("first_beat_t2", {RVALID, RDATA}, {1'b1, 32'h40});
    drain();
    send_ar(32'h0000_0103);
    drain();
    bp = 1;
    send_ar(32'h0000_2000);
    drain();
    bp = 0;
    repeat (2) @(posedge ACLK);
    #1;
    send_ar(32'h0000_4000);
    send_ar(32'h0000_8000);
    check("arready_pending_full", 64'(ARREADY), 64'h0);
    repeat (10) @(posedge ACLK);
    #1;
    check("arready_still_full", 64'(ARREADY), 64'h0);
    drain();
    check("b2b_run", 64'(max_run), 64'd128);
    send_ar(32'h0003_FFF0);
    drain();
    base = beats;
    send_ar(32'h0000_0000);
    t = 0;
    while (beats < base + 20 && t < 500) begin
      @(posedge ACLK); #1;
      t++;
    end
    check("reached_beat20", 64'(beats >= base + 20), 64'h1);
    ARST = 1;
    @(posedge ACLK); #1;
    ARST = 0;
    check("midburst_reset", {RDATA, 12'h0, MEM_ADDR, ARREADY, RVALID, RLAST, MEM_RDEN}, 64'h0);
    @(posedge ACLK); #1;
    check("arready_after_midreset", 64'(ARREADY), 64'h1);
    repeat (3) @(posedge ACLK);
    #1;
    check("no_beats_after_reset", 64'(RVALID), 64'h0);
    send_ar(32'h0000_0000);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired, required completion");
    $fatal(1);
  end
endmodule
